// File: rtl/comp_seq_ctrl.sv
// Serial magnitude comparator: walks two WIDTH-bit operands MSB-first, 2 bits per cycle,
// on one 2-bit compare slice and reports greater/equal/less with a done pulse.
module comp_seq_ctrl #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          op_a,
  input  logic [WIDTH-1:0]          op_b,
  output logic                      busy,
  output logic                      done,
  output logic                      greater,
  output logic                      equal,
  output logic                      less,
  output logic [$clog2(WIDTH/2):0]  slices
);
  localparam int NSLICE = WIDTH / 2;
  localparam int SW     = $clog2(NSLICE) + 1;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state, state_nxt;
  logic [NSLICE-1:0][1:0]  a_sl, b_sl;
  logic [IW-1:0]           idx;
  logic [SW-1:0]           cnt;
  logic                    decided, gt;
  logic                    diff, dec_now, gt_now, term;

  // Captured operands viewed as an array of 2-bit slices, slice 0 = LSBs.
  always_comb begin
    diff    = a_sl[idx] != b_sl[idx];
    dec_now = decided | diff;
    gt_now  = decided ? gt : (a_sl[idx] > b_sl[idx]);
    term    = (idx == '0) || ((EARLY_EXIT != 0) && diff);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (term)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sl    <= '0;
      b_sl    <= '0;
      idx     <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      gt      <= 1'b0;
      done    <= 1'b0;
      greater <= 1'b0;
      equal   <= 1'b0;
      less    <= 1'b0;
      slices  <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_sl    <= op_a;
          b_sl    <= op_b;
          idx     <= IW'(NSLICE - 1);
          cnt     <= '0;
          decided <= 1'b0;
        end
        RUN: begin
          cnt     <= cnt + 1'b1;
          decided <= dec_now;
          gt      <= gt_now;
          if (term) begin
            done    <= 1'b1;
            equal   <= ~dec_now;
            greater <= dec_now & gt_now;
            less    <= dec_now & ~gt_now;
            slices  <= cnt + 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
